somador_unit: RTL and testbench



---
 rtl/somador_unit.sv | 78 +++++++
 tb/tb_somador_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/somador_unit.sv
// One-bit full-adder cell with registered sum/carry and an optional bit-serial mode.
// Define SOMADOR_SERIAL_EN to build the internal carry flop, bit counter and word_done pulse.
module somador_unit #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i0,
  input  logic i1,
  input  logic ci,
  input  logic ser_en,
  input  logic ser_clr,
  output logic s,
  output logic co,
  output logic s_q,
  output logic co_q,
  output logic word_done
);

  logic w_cin_eff;

  assign s  = i0 ^ i1 ^ w_cin_eff;
  assign co = (i0 & i1) | (i0 & w_cin_eff) | (i1 & w_cin_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 1'b0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s;
      co_q <= co;
    end
  end

`ifdef SOMADOR_SERIAL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic          r_cy;
  logic [CW-1:0] r_bit_cnt;
  logic          r_word_done;

  assign w_cin_eff = ser_en ? r_cy : ci;
  assign word_done = r_word_done;

  // Clear wins over a serial step; the last bit restarts the word and flags completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cy        <= 1'b0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
    end else if (ser_clr) begin
      r_cy        <= 1'b0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
    end else if (ser_en) begin
      if (r_bit_cnt == LAST_BIT) begin
        r_cy        <= 1'b0;
        r_bit_cnt   <= '0;
        r_word_done <= 1'b1;
      end else begin
        r_cy        <= co;
        r_bit_cnt   <= r_bit_cnt + 1'b1;
        r_word_done <= 1'b0;
      end
    end else begin
      r_word_done <= 1'b0;
    end
  end
`else
  logic w_unused;

  assign w_cin_eff = ci;
  assign word_done = 1'b0;
  assign w_unused  = ^{ser_en, ser_clr, WIDTH[0]};
`endif

endmodule

// File: tb/tb_somador_unit.sv
// Self-checking bench for somador_unit: truth table, reset, serial words and random traffic
// compared against an arithmetic reference model.
module tb_somador_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i0 = 1'b0, i1 = 1'b0, ci = 1'b0, ser_en = 1'b0, ser_clr = 1'b0;
  logic s, co, s_q, co_q, word_done;

  int total = 0;
  int bad = 0;

  logic mCy = 1'b0;
  int   mCnt = 0;
  logic expSq = 1'b0, expCoq = 1'b0, expWd = 1'b0;

  always #5 clk = ~clk;

  somador_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .ci(ci),
    .ser_en(ser_en), .ser_clr(ser_clr),
    .s(s), .co(co), .s_q(s_q), .co_q(co_q), .word_done(word_done)
  );

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%b want=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: combinational checks before the edge, registered checks after it.
  task automatic applyStimulus(input logic a, input logic b, input logic c,
                               input logic en, input logic clr);
    logic cin;
    int   tot;
    @(negedge clk);
    i0 = a; i1 = b; ci = c; ser_en = en; ser_clr = clr;
`ifdef SOMADOR_SERIAL_EN
    cin = en ? mCy : c;
`else
    cin = c;
`endif
    tot = int'(a) + int'(b) + int'(cin);
    #1;
    checkOutput("s", s, tot[0]);
    checkOutput("co", co, tot[1]);
    @(posedge clk);
    expSq = tot[0];
    expCoq = tot[1];
    expWd = 1'b0;
`ifdef SOMADOR_SERIAL_EN
    if (clr) begin
      mCy = 1'b0;
      mCnt = 0;
    end else if (en) begin
      mCnt++;
      if (mCnt == W) begin
        mCy = 1'b0;
        mCnt = 0;
        expWd = 1'b1;
      end else begin
        mCy = tot[1];
      end
    end
`endif
    #1;
    checkOutput("s_q", s_q, expSq);
    checkOutput("co_q", co_q, expCoq);
    checkOutput("word_done", word_done, expWd);
  endtask

  // Asserts reset with all inputs high; carry-in must read as zero in serial mode.
  task automatic resetPulse();
    logic cin;
    int   tot;
    @(negedge clk);
    rst_n = 1'b0; i0 = 1'b1; i1 = 1'b1; ci = 1'b1; ser_en = 1'b1; ser_clr = 1'b0;
    mCy = 1'b0; mCnt = 0; expSq = 1'b0; expCoq = 1'b0; expWd = 1'b0;
`ifdef SOMADOR_SERIAL_EN
    cin = 1'b0;
`else
    cin = 1'b1;
`endif
    tot = 2 + int'(cin);
    #1;
    checkOutput("rst_s_q", s_q, 1'b0);
    checkOutput("rst_co_q", co_q, 1'b0);
    checkOutput("rst_word_done", word_done, 1'b0);
    checkOutput("rst_s", s, tot[0]);
    checkOutput("rst_co", co, tot[1]);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_s_q", s_q, 1'b0);
    checkOutput("rst_hold_co_q", co_q, 1'b0);
    checkOutput("rst_hold_word_done", word_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef SOMADOR_SERIAL_EN
  // Feeds an LSB-first word and checks the s_q stream against plain integer addition.
  task automatic addWord(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] want;
    want = {1'b0, a} + {1'b0, b};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      applyStimulus(a[i], b[i], 1'b0, 1'b1, 1'b0);
      checkOutput("sum_bit", s_q, want[i]);
    end
    checkOutput("word_done_last", word_done, 1'b1);
    checkOutput("word_carry", co_q, want[8]);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    logic [2:0] v;
    #2;
    checkOutput("init_s_q", s_q, 1'b0);
    checkOutput("init_co_q", co_q, 1'b0);
    checkOutput("init_word_done", word_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      applyStimulus(v[2], v[1], v[0], 1'b0, 1'b0);
    end

    resetPulse();

`ifdef SOMADOR_SERIAL_EN
    addWord(8'h5A, 8'h3C);
    addWord(8'hFF, 8'h01);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < W - 1; i++)
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);
    checkOutput("clr_no_early_done", word_done, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_full_word_done", word_done, 1'b1);

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    resetPulse();
    for (int i = 0; i < W - 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_abandons_word", word_done, 1'b0);
`else
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(3) != 0), 1'($urandom_range(15) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
